// File: rtl/lock_controller_if.sv
//------------------------------------------------------------------------------
// Module      : lock_controller_if
// Description : Keypad/status bundle between the lock sequencer and its
//               environment. The keypad side (master) drives the debounced
//               digit and clear pulses; the sequencer (slave) drives the
//               actuator, alarm, status and diagnostic outputs.
// Ports       : digit_valid, digit[3:0], clear_req     -> into sequencer
//               unlock, alarm, err, prog_done,
//               state_o[2:0], digit_cnt[3:0]           -> out of sequencer
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lock_controller_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear_req;
  logic       unlock;
  logic       alarm;
  logic       err;
  logic       prog_done;
  logic [2:0] state_o;
  logic [3:0] digit_cnt;

  modport master (
    output digit_valid, digit, clear_req,
    input  unlock, alarm, err, prog_done, state_o, digit_cnt
  );

  modport slave (
    input  digit_valid, digit, clear_req,
    output unlock, alarm, err, prog_done, state_o, digit_cnt
  );
endinterface

`default_nettype wire

// File: rtl/lock_controller.sv
//------------------------------------------------------------------------------
// Module      : lock_controller
// Description : Central sequencer of the electronic lock. Collects a BCD PIN
//               from single-cycle keypad pulses, compares it with the stored
//               PIN, drives unlock/alarm, and enforces a lockout after
//               MAX_TRIES consecutive failures. With the macro PIN_PROG_EN
//               defined, a clear_req while open enters PIN programming.
// Ports       : clk, rst (async, active-high)
//               bus (lock_controller_if.slave):
//                 in : digit_valid, digit[3:0], clear_req
//                 out: unlock, alarm, err, prog_done, state_o[2:0],
//                      digit_cnt[3:0]
// Options     : PIN_PROG_EN - enables the PROG state and a writable PIN
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lock_controller #(
  parameter int                      PIN_DIGITS     = 4,
  parameter logic [4*PIN_DIGITS-1:0] DEFAULT_PIN    = 16'h1234,
  parameter int                      MAX_TRIES      = 3,
  parameter int                      UNLOCK_CYCLES  = 5000,
  parameter int                      LOCKOUT_CYCLES = 50000,
  parameter int                      ENTRY_TIMEOUT  = 20000
) (
  input  wire               clk,
  input  wire               rst,
  lock_controller_if.slave  bus
);

  localparam int BUF_W   = 4 * PIN_DIGITS;
  localparam int MAX_UL  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_ALL = (MAX_UL > ENTRY_TIMEOUT) ? MAX_UL : ENTRY_TIMEOUT;
  localparam int TIMER_W = $clog2(MAX_ALL) + 1;
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  localparam logic [3:0]         C_PIN_DIGITS  = 4'(PIN_DIGITS);
  localparam logic [TRIES_W-1:0] C_MAX_TRIES   = TRIES_W'(MAX_TRIES);
  // Terminal counts: the timer starts at 0 on entry, so the last cycle of an
  // N-cycle interval is seen with timer == N-1.
  localparam logic [TIMER_W-1:0] C_UNLOCK_LAST = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_LOCK_LAST   = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_TMO_LAST    = TIMER_W'(ENTRY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROG    = 3'd5
  } state_t;

  state_t             state_q;
  logic [BUF_W-1:0]   buffer_q;
  logic [BUF_W-1:0]   buffer_d;
  logic [3:0]         digit_cnt_q;
  logic [3:0]         digit_cnt_d;
  logic [TRIES_W-1:0] tries_q;
  logic [TRIES_W-1:0] tries_d;
  logic [TIMER_W-1:0] timer_q;
  logic               err_q;
  logic [BUF_W-1:0]   w_pin;
  logic               w_digit_ok;
  logic               w_last;

  // Non-BCD codes are treated exactly like no digit at all.
  assign w_digit_ok  = bus.digit_valid && (bus.digit <= 4'd9);
  assign digit_cnt_d = digit_cnt_q + 4'd1;
  assign w_last      = (digit_cnt_d == C_PIN_DIGITS);
  assign tries_d     = tries_q + 1'b1;

  generate
    if (PIN_DIGITS == 1) begin : g_shift_single
      assign buffer_d = bus.digit;
    end else begin : g_shift_multi
      assign buffer_d = {buffer_q[BUF_W-5:0], bus.digit};
    end
  endgenerate

`ifdef PIN_PROG_EN
  logic [BUF_W-1:0] pin_q;
  logic             prog_done_q;
  assign w_pin         = pin_q;
  assign bus.prog_done = prog_done_q;
`else
  assign w_pin         = DEFAULT_PIN;
  assign bus.prog_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buffer_q    <= '0;
      digit_cnt_q <= '0;
      tries_q     <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
`ifdef PIN_PROG_EN
      pin_q       <= DEFAULT_PIN;
      prog_done_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef PIN_PROG_EN
      prog_done_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (bus.clear_req) begin
            buffer_q    <= '0;
            digit_cnt_q <= '0;
          end else if (w_digit_ok) begin
            buffer_q    <= buffer_d;
            digit_cnt_q <= digit_cnt_d;
            state_q     <= w_last ? S_CHECK : S_ENTRY;
          end
        end

        S_ENTRY, S_PROG: begin
          if (bus.clear_req) begin
            buffer_q    <= '0;
            digit_cnt_q <= '0;
            timer_q     <= '0;
            state_q     <= S_IDLE;
          end else if (w_digit_ok) begin
            timer_q <= '0;
            if (w_last) begin
`ifdef PIN_PROG_EN
              if (state_q == S_PROG) begin
                pin_q       <= buffer_d;
                prog_done_q <= 1'b1;
                buffer_q    <= '0;
                digit_cnt_q <= '0;
                state_q     <= S_IDLE;
              end else
`endif
              begin
                buffer_q    <= buffer_d;
                digit_cnt_q <= digit_cnt_d;
                state_q     <= S_CHECK;
              end
            end else begin
              buffer_q    <= buffer_d;
              digit_cnt_q <= digit_cnt_d;
            end
          end else if (timer_q == C_TMO_LAST) begin
            buffer_q    <= '0;
            digit_cnt_q <= '0;
            timer_q     <= '0;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_CHECK: begin
          buffer_q    <= '0;
          digit_cnt_q <= '0;
          timer_q     <= '0;
          if (buffer_q == w_pin) begin
            tries_q <= '0;
            state_q <= S_OPEN;
          end else begin
            err_q   <= 1'b1;
            tries_q <= tries_d;
            state_q <= (tries_d == C_MAX_TRIES) ? S_LOCKOUT : S_IDLE;
          end
        end

        S_OPEN: begin
          if (bus.clear_req) begin
            timer_q <= '0;
`ifdef PIN_PROG_EN
            state_q <= S_PROG;
`else
            state_q <= S_IDLE;
`endif
          end else if (timer_q == C_UNLOCK_LAST) begin
            timer_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_LOCKOUT: begin
          // Inputs deliberately ignored: the alarm interval cannot be cut short.
          if (timer_q == C_LOCK_LAST) begin
            timer_q <= '0;
            tries_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: begin
          buffer_q    <= '0;
          digit_cnt_q <= '0;
          timer_q     <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.unlock    = (state_q == S_OPEN);
  assign bus.alarm     = (state_q == S_LOCKOUT);
  assign bus.err       = err_q;
  assign bus.state_o   = state_q;
  assign bus.digit_cnt = digit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lock_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_lock_controller
// Description : Self-checking bench for lock_controller. A queue/countdown
//               reference model predicts every output each cycle; directed
//               scenarios plus a randomized phase drive the design.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lock_controller;

  localparam int C_UNLOCK = 10;
  localparam int C_LOCK   = 20;
  localparam int C_TMO    = 8;
  localparam int C_TRIES  = 3;
  localparam int C_DIGITS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lock_controller_if bus ();

  lock_controller #(
    .PIN_DIGITS     (C_DIGITS),
    .DEFAULT_PIN    (16'h1234),
    .MAX_TRIES      (C_TRIES),
    .UNLOCK_CYCLES  (C_UNLOCK),
    .LOCKOUT_CYCLES (C_LOCK),
    .ENTRY_TIMEOUT  (C_TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle_no = 0;

  // Pulse/level counters accumulated every cycle, cleared per scenario.
  int n_unlock, n_alarm, n_err, n_prog;

  // Reference model: 0 IDLE,1 ENTRY,2 CHECK,3 OPEN,4 LOCKOUT,5 PROG
  int m_state;
  int m_q[$];
  int m_pin;
  int m_tries;
  int m_left;
  int m_idle;
  bit m_err;
  bit m_prog;

  function automatic int q_value();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_q.delete(); m_pin = 'h1234; m_tries = 0;
    m_left = 0; m_idle = 0; m_err = 0; m_prog = 0;
  endtask

  task automatic model_step(input bit dv, input int d, input bit clr);
    bit ok;
    ok = dv && (d < 10);
    m_err = 0; m_prog = 0;
    case (m_state)
      0: begin
        if (clr) m_q.delete();
        else if (ok) begin
          m_q.push_back(d); m_idle = 0;
          m_state = (m_q.size() == C_DIGITS) ? 2 : 1;
        end
      end
      1, 5: begin
        if (clr) begin m_q.delete(); m_state = 0; end
        else if (ok) begin
          m_q.push_back(d); m_idle = 0;
          if (m_q.size() == C_DIGITS) begin
            if (m_state == 5) begin
              m_pin = q_value(); m_prog = 1; m_q.delete(); m_state = 0;
            end else m_state = 2;
          end
        end else begin
          m_idle++;
          if (m_idle == C_TMO) begin m_q.delete(); m_state = 0; end
        end
      end
      2: begin
        if (q_value() == m_pin) begin
          m_state = 3; m_left = C_UNLOCK; m_tries = 0;
        end else begin
          m_err = 1; m_tries++;
          if (m_tries == C_TRIES) begin m_state = 4; m_left = C_LOCK; end
          else m_state = 0;
        end
        m_q.delete();
      end
      3: begin
        if (clr) begin
`ifdef PIN_PROG_EN
          m_state = 5; m_idle = 0;
`else
          m_state = 0;
`endif
        end else begin
          m_left--;
          if (m_left == 0) m_state = 0;
        end
      end
      4: begin
        m_left--;
        if (m_left == 0) begin m_state = 0; m_tries = 0; end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cycle_no, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/state"},     32'(bus.state_o),   32'(m_state));
    chk({tag, "/unlock"},    32'(bus.unlock),    32'(m_state == 3));
    chk({tag, "/alarm"},     32'(bus.alarm),     32'(m_state == 4));
    chk({tag, "/err"},       32'(bus.err),       32'(m_err));
    chk({tag, "/prog_done"}, 32'(bus.prog_done), 32'(m_prog));
    chk({tag, "/digit_cnt"}, 32'(bus.digit_cnt), 32'(m_q.size()));
  endtask

  task automatic cyc(input bit dv, input int d, input bit clr);
    logic [31:0] dv32;
    dv32 = 32'(d);
    bus.digit_valid = dv;
    bus.digit       = dv32[3:0];
    bus.clear_req   = clr;
    @(posedge clk);
    model_step(dv, d, clr);
    #1;
    cycle_no++;
    check_outputs("cyc");
    if (bus.unlock === 1'b1)    n_unlock++;
    if (bus.alarm === 1'b1)     n_alarm++;
    if (bus.err === 1'b1)       n_err++;
    if (bus.prog_done === 1'b1) n_prog++;
    bus.digit_valid = 1'b0;
    bus.clear_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    cyc(1'b1, a, 1'b0); cyc(1'b1, b, 1'b0);
    cyc(1'b1, c, 1'b0); cyc(1'b1, d, 1'b0);
  endtask

  task automatic clr_counts();
    n_unlock = 0; n_alarm = 0; n_err = 0; n_prog = 0;
  endtask

  // Asynchronous reset between edges: outputs must drop without a clock edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    chk({tag, "/unlock"}, 32'(bus.unlock),  32'd0);
    chk({tag, "/alarm"},  32'(bus.alarm),   32'd0);
    chk({tag, "/state"},  32'(bus.state_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.clear_req   = 1'b0;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1. Correct PIN
    clr_counts();
    enter(1, 2, 3, 4);
    chk("t1_check_state", 32'(bus.state_o), 32'd2);
    cyc(1'b0, 0, 1'b0);
    chk("t1_unlock_rise", 32'(bus.unlock), 32'd1);
    idle(14);
    chk("t1_unlock_width", 32'(n_unlock), 32'(C_UNLOCK));
    chk("t1_back_idle", 32'(bus.state_o), 32'd0);

    // 2. Lockout, inputs ignored while alarmed, then recovery
    clr_counts();
    for (int k = 0; k < 3; k++) begin
      enter(1, 1, 1, 1);
      cyc(1'b0, 0, 1'b0);
    end
    enter(1, 2, 3, 4);
    cyc(1'b0, 0, 1'b1);
    idle(20);
    chk("t2_err_pulses", 32'(n_err), 32'd3);
    chk("t2_alarm_width", 32'(n_alarm), 32'(C_LOCK));
    chk("t2_no_unlock", 32'(n_unlock), 32'd0);
    enter(1, 2, 3, 4);
    cyc(1'b0, 0, 1'b0);
    chk("t2_unlock_after", 32'(bus.unlock), 32'd1);
    idle(12);

    // 3. Clear and timeout
    clr_counts();
    cyc(1'b1, 1, 1'b0); cyc(1'b1, 2, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk("t3_clear_cnt", 32'(bus.digit_cnt), 32'd0);
    cyc(1'b1, 1, 1'b0);
    idle(7);
    chk("t3_before_tmo", 32'(bus.state_o), 32'd1);
    cyc(1'b0, 0, 1'b0);
    chk("t3_after_tmo", 32'(bus.state_o), 32'd0);
    chk("t3_no_err", 32'(n_err), 32'd0);

    // 4. clear_req together with the last digit
    clr_counts();
    cyc(1'b1, 1, 1'b0); cyc(1'b1, 2, 1'b0); cyc(1'b1, 3, 1'b0);
    cyc(1'b1, 4, 1'b1);
    idle(3);
    chk("t4_no_unlock", 32'(n_unlock), 32'd0);
    chk("t4_no_err", 32'(n_err), 32'd0);

    // 5. clear_req while open
    clr_counts();
    enter(1, 2, 3, 4);
    idle(2);
    cyc(1'b0, 0, 1'b1);
    chk("t5_unlock_drop", 32'(bus.unlock), 32'd0);
`ifdef PIN_PROG_EN
    enter(9, 8, 7, 6);
    chk("t5_prog_done", 32'(n_prog), 32'd1);
    enter(1, 2, 3, 4);
    cyc(1'b0, 0, 1'b0);
    chk("t5_old_pin_err", 32'(bus.err), 32'd1);
    enter(9, 8, 7, 6);
    cyc(1'b0, 0, 1'b0);
    chk("t5_new_pin_unlock", 32'(bus.unlock), 32'd1);
    idle(12);
`else
    chk("t5_relock_state", 32'(bus.state_o), 32'd0);
    chk("t5_no_prog", 32'(n_prog), 32'd0);
`endif

    // 6. Reset during OPEN and during LOCKOUT
    enter(1, 2, 3, 4);
    idle(3);
    async_reset("t6_open_rst");
    enter(1, 2, 3, 4);
    cyc(1'b0, 0, 1'b0);
    chk("t6_unlock_after_rst", 32'(bus.unlock), 32'd1);
    idle(12);
    for (int k = 0; k < 3; k++) begin
      enter(1, 1, 1, 1);
      cyc(1'b0, 0, 1'b0);
    end
    idle(4);
    async_reset("t6_lock_rst");
    enter(1, 2, 3, 4);
    cyc(1'b0, 0, 1'b0);
    chk("t6_unlock_after_lock_rst", 32'(bus.unlock), 32'd1);
    idle(12);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) enter(1, 2, 3, 4);
      else cyc(r < 50, int'($urandom_range(0, 15)), r >= 94);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
